// File: rtl/mmv_output_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmv_output_packer_if
//  Description : Stream bundle for the MMV output packer. It carries the
//                serial per-fold input stream and the multi-pixel output beats.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmv_output_packer_if #(
    parameter int DATA_W  = 8,
    parameter int MMV_OUT = 2
);
    logic [DATA_W-1:0]         ip_axis_tdata;
    logic                      ip_axis_tvalid;
    logic                      ip_axis_tready;
    logic [MMV_OUT*DATA_W-1:0] op_axis_tdata;
    logic                      op_axis_tvalid;
    logic                      op_axis_tready;
    logic [MMV_OUT-1:0]        op_lane_valid;
    logic                      op_axis_tlast;

    // Packer side
    modport slave (
        input  ip_axis_tdata, ip_axis_tvalid, op_axis_tready,
        output ip_axis_tready, op_axis_tdata, op_axis_tvalid, op_lane_valid, op_axis_tlast
    );

    // Environment side
    modport master (
        output ip_axis_tdata, ip_axis_tvalid, op_axis_tready,
        input  ip_axis_tready, op_axis_tdata, op_axis_tvalid, op_lane_valid, op_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/mmv_output_packer.sv
`default_nettype none
// ============================================================================
//  Module      : mmv_output_packer
//  Description : Regroups the compute array's pixel-major/fold-minor stream
//                into beats carrying one channel fold for MMV_OUT pixels.
//                Ping-pong banks let one group fill while the other drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmv_output_packer #(
    parameter int    PE           = 1,
    parameter int    OP_PRECISION = 8,
    parameter int    OFMChannels  = 2,
    parameter int    OFMWidth     = 6,
    parameter int    OFMHeight    = 6,
    parameter int    MMV_OUT      = 2,
    parameter string RAM_STYLE    = "auto"
) (
    input  logic                clk,
    input  logic                rst,
    mmv_output_packer_if.slave  axis
);
    localparam int c_data_w = PE * OP_PRECISION;
    localparam int c_eff    = OFMChannels / PE;
    localparam int c_fold_w = (c_eff > 1)     ? $clog2(c_eff)     : 1;
    localparam int c_lane_w = (MMV_OUT > 1)   ? $clog2(MMV_OUT)   : 1;
    localparam int c_col_w  = (OFMWidth > 1)  ? $clog2(OFMWidth)  : 1;
    localparam int c_row_w  = (OFMHeight > 1) ? $clog2(OFMHeight) : 1;
    localparam int c_cnt_w  = $clog2(MMV_OUT + 1);
    localparam int c_depth  = 2 * c_eff * MMV_OUT;
    localparam int c_addr_w = $clog2(c_depth);

    // Bank storage: address = (bank * c_eff + fold) * MMV_OUT + lane
    (* ram_style = RAM_STYLE *) logic [c_data_w-1:0] r_mem [c_depth];

    logic                  r_run;
    logic [1:0]            r_full;
    logic [1:0]            r_last;
    logic [c_cnt_w-1:0]    r_cnt [2];
    logic                  r_wb;
    logic [c_fold_w-1:0]   r_c;
    logic [c_lane_w-1:0]   r_w;
    logic [c_col_w-1:0]    r_col;
    logic [c_row_w-1:0]    r_row;
    logic                  r_rb;
    logic [c_fold_w-1:0]   r_rc;
    logic [MMV_OUT*c_data_w-1:0] r_out_data;
    logic [MMV_OUT-1:0]    r_out_lv;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic                  w_in_ready;
    logic                  w_in_hs;
    logic                  w_fold_end;
    logic                  w_lane_end;
    logic                  w_col_end;
    logic                  w_row_end;
    logic                  w_close;
    logic                  w_load;
    logic                  w_rc_end;
    logic [1:0]            w_set;
    logic [1:0]            w_clr;
    logic [c_addr_w-1:0]   w_wr_addr;
    logic [MMV_OUT*c_data_w-1:0] w_beat;
    logic [MMV_OUT-1:0]    w_lv;

    // r_run holds ready low until the first edge after reset release
    assign w_in_ready = r_run & ~r_full[r_wb];
    assign w_in_hs    = axis.ip_axis_tvalid & w_in_ready;
    assign w_fold_end = (r_c == c_fold_w'(c_eff - 1));
    assign w_lane_end = (r_w == c_lane_w'(MMV_OUT - 1));
    assign w_col_end  = (r_col == c_col_w'(OFMWidth - 1));
    assign w_row_end  = (r_row == c_row_w'(OFMHeight - 1));
    assign w_close    = w_in_hs & w_fold_end & (w_lane_end | w_col_end);
    assign w_set      = w_close ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
    assign w_load     = (axis.op_axis_tready | ~r_out_valid) & r_full[r_rb];
    assign w_rc_end   = (r_rc == c_fold_w'(c_eff - 1));
    assign w_clr      = (w_load & w_rc_end) ? (r_rb ? 2'b10 : 2'b01) : 2'b00;
    assign w_wr_addr  = c_addr_w'((32'(r_wb) * c_eff + 32'(r_c)) * MMV_OUT + 32'(r_w));

    assign axis.ip_axis_tready = w_in_ready;
    assign axis.op_axis_tdata  = r_out_data;
    assign axis.op_lane_valid  = r_out_lv;
    assign axis.op_axis_tvalid = r_out_valid;
    assign axis.op_axis_tlast  = r_out_last;

    // Gather the current fold of the draining bank; lanes past the count read as zero
    always_comb begin
        w_beat = '0;
        w_lv   = '0;
        for (int w = 0; w < MMV_OUT; w++) begin
            if (32'(r_cnt[r_rb]) > w) begin
                w_beat[w*c_data_w +: c_data_w] =
                    r_mem[c_addr_w'((32'(r_rb) * c_eff + 32'(r_rc)) * MMV_OUT + w)];
                w_lv[w] = 1'b1;
            end
        end
    end

    // Bank write port; contents need no reset since lane counts gate every read
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_mem[w_wr_addr] <= axis.ip_axis_tdata;
        end
    end

    // Write-side position counters and per-bank group descriptors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_wb     <= 1'b0;
            r_c      <= '0;
            r_w      <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_last   <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_in_hs) begin
                if (w_fold_end) begin
                    r_c <= '0;
                    if (w_close) begin
                        r_cnt[r_wb]  <= c_cnt_w'(r_w) + 1'b1;
                        r_last[r_wb] <= w_row_end & w_col_end;
                        r_wb         <= ~r_wb;
                        r_w          <= '0;
                    end else begin
                        r_w <= r_w + 1'b1;
                    end
                    if (w_col_end) begin
                        r_col <= '0;
                        r_row <= w_row_end ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_c <= r_c + 1'b1;
                end
            end
        end
    end

    // Full flags: writer sets on group close, reader clears on loading the last fold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
        end
    end

    // One-stage output register; holds steady while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb        <= 1'b0;
            r_rc        <= '0;
            r_out_data  <= '0;
            r_out_lv    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_beat;
            r_out_lv    <= w_lv;
            r_out_last  <= r_last[r_rb] & w_rc_end;
            r_out_valid <= 1'b1;
            if (w_rc_end) begin
                r_rc <= '0;
                r_rb <= ~r_rb;
            end else begin
                r_rc <= r_rc + 1'b1;
            end
        end else if (axis.op_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: doc/mmv_output_packer.md
Name:
mmv_output_packer

Overview:
- Output-side counterpart of the MMV input sliding-window unit.
- Accepts the compute array's serial output stream: one PE-wide channel fold per handshake, in pixel-major, fold-minor order.
- Regroups MMV_OUT consecutive OFM pixels and emits one beat per channel fold; each beat carries that fold for all MMV_OUT pixels.
- The output beat layout is the multi-pixel layout the downstream MMV input SWU consumes.
- Ping-pong buffered so one group is written while the previous group drains.

Parameters:
- PE, 1, channels per input beat.
- OP_PRECISION, 8, bits per channel element.
- OFMChannels, 2, output channels; must be a multiple of PE. EFF_CHANNELS = OFMChannels/PE.
- OFMWidth, 6, OFM pixels per row.
- OFMHeight, 6, OFM rows per image.
- MMV_OUT, 2, pixels packed per output beat; must be >= 1.
- RAM_STYLE, "auto", synthesis hint for the bank storage.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ip_axis_tdata  in  PE*OP_PRECISION  one channel fold of one pixel.
- ip_axis_tvalid  in  1  input valid.
- ip_axis_tready  out  1  input ready.
- op_axis_tdata  out  MMV_OUT*PE*OP_PRECISION  lane w occupies bits [(w+1)*PE*OP_PRECISION-1 : w*PE*OP_PRECISION]; lane 0 is the earliest pixel.
- op_axis_tvalid  out  1  output valid.
- op_axis_tready  in  1  output ready.
- op_lane_valid  out  MMV_OUT  bit w set when lane w holds a real pixel.
- op_axis_tlast  out  1  high on the final beat of an image.

Behaviour:
- Reset (asynchronous, any time, including mid-group): all outputs go to 0 and all counters and bank flags clear. Any partially written or undrained group is discarded. ip_axis_tready rises on the first clock edge after rst is deasserted.

Storage:
- Two banks, each holding EFF_CHANNELS x MMV_OUT entries of PE*OP_PRECISION bits.
- Each bank has a full flag, a lane-count field (1..MMV_OUT) and a last-group flag.

Write side:
- Counters: fold c (0..EFF_CHANNELS-1), lane w (0..MMV_OUT-1), column col, row.
- ip_axis_tready = !full[wb].
- On each input handshake, write bank[wb][c][w], then increment c.
- When c wraps, increment w and col.
- The group closes on c==EFF_CHANNELS-1 handshake when either w==MMV_OUT-1 or col==OFMWidth-1.
- On close: set full[wb], store lane count = w+1, store last = (row==OFMHeight-1 && col==OFMWidth-1), toggle wb, reset w to 0.
- col==OFMWidth-1 also resets col to 0 and advances row; row wraps to 0 after OFMHeight-1.
- Groups therefore never span rows. The trailing partial group of a row has OFMWidth mod MMV_OUT lanes.

Read side:
- Fold counter rc and bank pointer rb drive a one-stage registered output; read latency is 1 cycle.
- op_axis_tvalid may first assert 1 cycle after the handshake that closes a group.
- Output register loads when (op_axis_tready | !op_axis_tvalid) and full[rb] and a beat remains.
- Beat rc contents: lanes 0..MMV_OUT-1 of bank[rb][rc]. Lanes >= lane count are forced to zero.
- op_lane_valid = (1<<count)-1.
- op_axis_tlast = last flag && rc==EFF_CHANNELS-1.
- When beat EFF_CHANNELS-1 is loaded, clear full[rb], toggle rb, reset rc.

Streaming and stalls:
- With no backpressure, throughput is 1 beat/cycle. Back-to-back groups stream with no bubbles.
- Setting full on one bank and clearing it on the other in the same cycle is legal and both take effect.
- Both banks full: ip_axis_tready=0 until the reader frees a bank. The freed bank is writable the cycle after its full clears.
- op_axis_tdata, op_axis_tlast and op_lane_valid hold stable while op_axis_tvalid=1 and op_axis_tready=0 (AXI-Stream rule).

Image boundary:
- After the last group of an image, the writer continues into the next image with no gap; counters wrap naturally.

Test Plan:
1. PE=1, prec 8, OFMChannels=2, OFMWidth=5, OFMHeight=2, MMV_OUT=2, tready=1; input bytes 0x00,0x01,0x02,... -> first beats 0x0200, 0x0301 (lane_valid=11); row-end group: 0x0008, 0x0009 (lane_valid=01).
2. Same config, full image of 20 bytes -> 12 beats total; tlast only on beat 12 (data 0x0013, lane_valid=01).
3. op_axis_tready held low for 20 cycles -> exactly 8 input handshakes accepted (both banks full), then ip_axis_tready=0; output data stable; all 12 beats still delivered in order after release.
4. Random tvalid/tready toggling over 3 images -> output equals a golden regroup model; no loss or duplication.
5. Assert rst after 3 input beats, then restart the image -> no stale output; first beats are 0x0200, 0x0301 as in test 1.
6. MMV_OUT=1, OFMWidth=3 -> output equals input unchanged; lane_valid=1 on every beat.
